// File: rtl/iob_mem_arbiter_pkg.sv
// Shared types for the IOb memory arbiter.
//   owner_e     : which requester issued an outstanding read (fetch / data)
//   fsm_state_e : fence sequencer states
//   pick_rr     : round-robin pick between the two requesters
package iob_mem_arbiter_pkg;

  typedef enum logic {
    OWN_IF = 1'b0,
    OWN_D  = 1'b1
  } owner_e;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    DRAIN = 2'd1,
    INV   = 2'd2,
    DONE  = 2'd3
  } fsm_state_e;

  // When both request, the one not granted last time wins.
  function automatic owner_e pick_rr(input logic req0, input logic req1,
                                     input owner_e last);
    owner_e w;
    if (req0 && req1) w = (last == OWN_D) ? OWN_IF : OWN_D;
    else if (req0)    w = OWN_IF;
    else              w = OWN_D;
    return w;
  endfunction

endpackage

// File: rtl/iob_mem_arbiter_fifo.sv
// iob_owner_fifo: 1-bit wide, 2**OUTS_W deep owner FIFO.
// Holds the issuer of each accepted read so responses can be steered back.
//   clk_i, arst_n_i, cke_i : clock, async active-low reset, clock enable
//   push_i / din_i         : write one owner bit
//   pop_i  / dout_o        : consume the head entry (dout_o shows head)
//   full_o / empty_o       : occupancy flags
// Push and pop in the same cycle are both performed; a push into a full
// FIFO is only taken when a pop frees the slot in the same cycle.
module iob_owner_fifo #(
  parameter int OUTS_W = 2
) (
  input  logic clk_i,
  input  logic arst_n_i,
  input  logic cke_i,
  input  logic push_i,
  input  logic din_i,
  input  logic pop_i,
  output logic dout_o,
  output logic full_o,
  output logic empty_o
);

  localparam int DEPTH = 1 << OUTS_W;

  logic [DEPTH-1:0]  mem;
  logic [OUTS_W-1:0] wr_ptr, rd_ptr;
  logic [OUTS_W:0]   cnt;
  logic              do_push, do_pop;

  assign full_o  = (cnt == (OUTS_W+1)'(DEPTH));
  assign empty_o = (cnt == '0);
  assign do_pop  = pop_i & ~empty_o;
  assign do_push = push_i & (~full_o | do_pop);
  assign dout_o  = mem[rd_ptr];

  always_ff @(posedge clk_i or negedge arst_n_i) begin
    if (!arst_n_i) begin
      mem    <= '0;
      wr_ptr <= '0;
      rd_ptr <= '0;
      cnt    <= '0;
    end else if (cke_i) begin
      if (do_push) begin
        mem[wr_ptr] <= din_i;
        wr_ptr      <= wr_ptr + 1'b1;
      end
      if (do_pop) rd_ptr <= rd_ptr + 1'b1;
      case ({do_push, do_pop})
        2'b10:   cnt <= cnt + 1'b1;
        2'b01:   cnt <= cnt - 1'b1;
        default: cnt <= cnt;
      endcase
    end
  end

endmodule

// File: rtl/iob_mem_arbiter.sv
// iob_mem_arbiter: shares the cache IOb front-end between instruction fetch
// (m0, read-only) and the load/store unit (m1).
//   m0_*  : fetch request / response
//   m1_*  : data request (wstrb==0 means read) / response
//   s_*   : request to and response from the cache
//   fence_i / fence_done_o / invalidate_o / wtb_empty_i : fence sequencing
//   err_o : sticky, a response arrived with no outstanding read recorded
// Arbitration is combinational in IDLE; a stalled request is locked to its
// owner until the cache accepts it. Read owners queue in iob_owner_fifo.
module iob_mem_arbiter
  import iob_mem_arbiter_pkg::*;
#(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32,
  parameter int OUTS_W = 2
) (
  input  logic                clk_i,
  input  logic                cke_i,
  input  logic                arst_n_i,
  input  logic                m0_valid_i,
  input  logic [ADDR_W-1:0]   m0_addr_i,
  output logic                m0_ready_o,
  output logic                m0_rvalid_o,
  output logic [DATA_W-1:0]   m0_rdata_o,
  input  logic                m1_valid_i,
  input  logic [ADDR_W-1:0]   m1_addr_i,
  input  logic [DATA_W-1:0]   m1_wdata_i,
  input  logic [DATA_W/8-1:0] m1_wstrb_i,
  output logic                m1_ready_o,
  output logic                m1_rvalid_o,
  output logic [DATA_W-1:0]   m1_rdata_o,
  output logic                s_valid_o,
  output logic [ADDR_W-1:0]   s_addr_o,
  output logic [DATA_W-1:0]   s_wdata_o,
  output logic [DATA_W/8-1:0] s_wstrb_o,
  input  logic                s_ready_i,
  input  logic                s_rvalid_i,
  input  logic [DATA_W-1:0]   s_rdata_i,
  input  logic                fence_i,
  output logic                fence_done_o,
  output logic                invalidate_o,
  input  logic                wtb_empty_i,
  output logic                err_o
);

  fsm_state_e state, state_nxt;
  logic       lock;
  owner_e     lock_own;
  owner_e     rr_last;   // owner of the last accepted request
  owner_e     grant;
  logic       s_valid;
  logic       accept;
  logic       m0_elig, m1_elig, m1_is_rd;
  logic       fifo_push, fifo_full, fifo_empty, fifo_head;
  logic       rsp_ok;

  // A read cannot be forwarded when the owner FIFO is full; writes are
  // untracked and may still go, so the other master's write can win.
  assign m1_is_rd = (m1_wstrb_i == '0);
  assign m0_elig  = m0_valid_i & ~fifo_full;
  assign m1_elig  = m1_valid_i & (~m1_is_rd | ~fifo_full);

  always_comb begin
    grant   = OWN_IF;
    s_valid = 1'b0;
    if (state == IDLE) begin
      if (lock) begin
        // Stalled handshake completes even if a fence arrived meanwhile.
        grant   = lock_own;
        s_valid = 1'b1;
      end else if (!fence_i && (m0_elig || m1_elig)) begin
        grant   = pick_rr(m0_elig, m1_elig, rr_last);
        s_valid = 1'b1;
      end
    end
  end

  always_comb begin
    s_addr_o  = '0;
    s_wdata_o = '0;
    s_wstrb_o = '0;
    if (s_valid) begin
      if (grant == OWN_D) begin
        s_addr_o  = m1_addr_i;
        s_wdata_o = m1_wdata_i;
        s_wstrb_o = m1_wstrb_i;
      end else begin
        s_addr_o  = m0_addr_i;
      end
    end
  end

  assign s_valid_o  = s_valid;
  assign accept     = s_valid & s_ready_i;
  assign m0_ready_o = accept & (grant == OWN_IF);
  assign m1_ready_o = accept & (grant == OWN_D);
  assign fifo_push  = accept & (s_wstrb_o == '0);

  iob_owner_fifo #(.OUTS_W(OUTS_W)) u_owner_fifo (
    .clk_i    (clk_i),
    .arst_n_i (arst_n_i),
    .cke_i    (cke_i),
    .push_i   (fifo_push),
    .din_i    (grant == OWN_D),
    .pop_i    (s_rvalid_i),
    .dout_o   (fifo_head),
    .full_o   (fifo_full),
    .empty_o  (fifo_empty)
  );

  // Response steering from the FIFO head; unowned responses are dropped.
  assign rsp_ok      = s_rvalid_i & ~fifo_empty;
  assign m0_rvalid_o = rsp_ok & ~fifo_head;
  assign m1_rvalid_o = rsp_ok &  fifo_head;
  assign m0_rdata_o  = m0_rvalid_o ? s_rdata_i : '0;
  assign m1_rdata_o  = m1_rvalid_o ? s_rdata_i : '0;

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (fence_i && !lock) state_nxt = DRAIN;
      DRAIN:   if (fifo_empty && wtb_empty_i) state_nxt = INV;
      INV:     state_nxt = DONE;
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  assign invalidate_o = (state == INV);
  assign fence_done_o = (state == DONE);

  always_ff @(posedge clk_i or negedge arst_n_i) begin
    if (!arst_n_i) begin
      state    <= IDLE;
      lock     <= 1'b0;
      lock_own <= OWN_IF;
      rr_last  <= OWN_IF;   // m1 wins the first tie
      err_o    <= 1'b0;
    end else if (cke_i) begin
      state <= state_nxt;
      lock  <= s_valid & ~s_ready_i;
      if (s_valid && !s_ready_i) lock_own <= grant;
      if (accept) rr_last <= grant;
      if (s_rvalid_i && fifo_empty) err_o <= 1'b1;
    end
  end

endmodule

// File: tb/tb_iob_mem_arbiter.sv
// Directed table-driven bench for iob_mem_arbiter. Each table row is one
// clock cycle: inputs are driven 1ns after the rising edge and outputs are
// compared on the falling edge.
module tb_iob_mem_arbiter;

  localparam logic [1:0] G_NO = 2'd0, G_M0 = 2'd1, G_M1 = 2'd2;

  typedef struct packed {
    logic        cke;
    logic        m0v;
    logic [31:0] m0a;
    logic        m1v;
    logic [31:0] m1a;
    logic [31:0] m1wd;
    logic [3:0]  m1ws;
    logic        srdy;
    logic        srv;
    logic [31:0] srd;
    logic        fence;
    logic        wtbe;
  } in_t;

  typedef struct packed {
    logic        m0r;
    logic        m1r;
    logic        m0rv;
    logic [31:0] m0rd;
    logic        m1rv;
    logic [31:0] m1rd;
    logic        sv;
    logic [31:0] sa;
    logic [31:0] swd;
    logic [3:0]  sws;
    logic        inv;
    logic        done;
    logic        err;
  } out_t;

  logic        clk = 1'b0;
  logic        cke, arst_n;
  logic        m0_valid, m0_ready, m0_rvalid;
  logic [31:0] m0_addr, m0_rdata;
  logic        m1_valid, m1_ready, m1_rvalid;
  logic [31:0] m1_addr, m1_wdata, m1_rdata;
  logic [3:0]  m1_wstrb;
  logic        s_valid, s_ready, s_rvalid;
  logic [31:0] s_addr, s_wdata, s_rdata;
  logic [3:0]  s_wstrb;
  logic        fence, fence_done, invalidate, wtb_empty, err;

  int checks = 0;
  int errors = 0;

  in_t   tin[$];
  out_t  texp[$];
  string tnm[$];
  int    split;

  always #5 clk = ~clk;

  iob_mem_arbiter #(.ADDR_W(32), .DATA_W(32), .OUTS_W(2)) dut (
    .clk_i(clk), .cke_i(cke), .arst_n_i(arst_n),
    .m0_valid_i(m0_valid), .m0_addr_i(m0_addr), .m0_ready_o(m0_ready),
    .m0_rvalid_o(m0_rvalid), .m0_rdata_o(m0_rdata),
    .m1_valid_i(m1_valid), .m1_addr_i(m1_addr), .m1_wdata_i(m1_wdata),
    .m1_wstrb_i(m1_wstrb), .m1_ready_o(m1_ready),
    .m1_rvalid_o(m1_rvalid), .m1_rdata_o(m1_rdata),
    .s_valid_o(s_valid), .s_addr_o(s_addr), .s_wdata_o(s_wdata),
    .s_wstrb_o(s_wstrb), .s_ready_i(s_ready), .s_rvalid_i(s_rvalid),
    .s_rdata_i(s_rdata), .fence_i(fence), .fence_done_o(fence_done),
    .invalidate_o(invalidate), .wtb_empty_i(wtb_empty), .err_o(err)
  );

  function automatic logic [31:0] wd(input logic [31:0] a);
    return {16'hD0D0, a[15:0]};
  endfunction

  // One row: inputs, then hand-chosen grant (g), response target (rv) and
  // the expected fence/err flags. Field-level expectations follow from them.
  task automatic add(input string nm, input logic ck, input logic m0v,
                     input logic [31:0] m0a, input logic m1v,
                     input logic [31:0] m1a, input logic [3:0] ws,
                     input logic srdy, input logic srv, input logic [31:0] srd,
                     input logic fen, input logic wtbe,
                     input logic [1:0] g, input logic [1:0] rv,
                     input logic inv, input logic dn, input logic er);
    in_t  i;
    out_t e;
    i = '{cke: ck, m0v: m0v, m0a: m0a, m1v: m1v, m1a: m1a, m1wd: wd(m1a),
          m1ws: ws, srdy: srdy, srv: srv, srd: srd, fence: fen, wtbe: wtbe};
    e = '0;
    e.sv   = (g != G_NO);
    e.sa   = (g == G_M0) ? m0a : (g == G_M1) ? m1a : 32'h0;
    e.swd  = (g == G_M1) ? wd(m1a) : 32'h0;
    e.sws  = (g == G_M1) ? ws : 4'h0;
    e.m0r  = (g == G_M0) & srdy;
    e.m1r  = (g == G_M1) & srdy;
    e.m0rv = (rv == G_M0);
    e.m0rd = (rv == G_M0) ? srd : 32'h0;
    e.m1rv = (rv == G_M1);
    e.m1rd = (rv == G_M1) ? srd : 32'h0;
    e.inv  = inv;
    e.done = dn;
    e.err  = er;
    tin.push_back(i);
    texp.push_back(e);
    tnm.push_back(nm);
  endtask

  task automatic drive(input in_t i);
    cke = i.cke;   m0_valid = i.m0v; m0_addr = i.m0a;
    m1_valid = i.m1v; m1_addr = i.m1a; m1_wdata = i.m1wd; m1_wstrb = i.m1ws;
    s_ready = i.srdy; s_rvalid = i.srv; s_rdata = i.srd;
    fence = i.fence; wtb_empty = i.wtbe;
  endtask

  task automatic compare(input string nm, input out_t e);
    out_t a;
    a = '{m0r: m0_ready, m1r: m1_ready, m0rv: m0_rvalid, m0rd: m0_rdata,
          m1rv: m1_rvalid, m1rd: m1_rdata, sv: s_valid, sa: s_addr,
          swd: s_wdata, sws: s_wstrb, inv: invalidate, done: fence_done,
          err: err};
    // Request fields are only meaningful with s_valid_o; rdata only with
    // a response present.
    if (!e.sv) begin a.sa = '0; a.swd = '0; a.sws = '0; end
    if (!e.m0rv && !e.m1rv) begin a.m0rd = '0; a.m1rd = '0; end
    checks++;
    if (a !== e) begin
      errors++;
      $display("FAIL %s: got %h expected %h", nm, a, e);
    end
  endtask

  task automatic run_row(input int k);
    drive(tin[k]);
    @(negedge clk);
    compare(tnm[k], texp[k]);
    @(posedge clk);
    #1;
  endtask

  initial begin
    //   name            ck m0v m0a      m1v m1a      ws   rdy rv srd           fen wtb g     rv    inv dn er
    add("m0_alone",       1, 1, 32'h100, 0, 32'h000, 4'h0, 1, 0, 32'h0,        0, 1, G_M0, G_NO, 0, 0, 0);
    add("m0_rsp",         1, 0, 32'h000, 0, 32'h000, 4'h0, 1, 1, 32'hDEADBEEF, 0, 1, G_NO, G_M0, 0, 0, 0);
    add("rr_m1",          1, 1, 32'h104, 1, 32'h204, 4'h0, 1, 0, 32'h0,        0, 1, G_M1, G_NO, 0, 0, 0);
    add("rr_m0_rsp1",     1, 1, 32'h104, 1, 32'h204, 4'h0, 1, 1, 32'h1,        0, 1, G_M0, G_M1, 0, 0, 0);
    add("rr_m1_rsp2",     1, 1, 32'h104, 1, 32'h204, 4'h0, 1, 1, 32'h2,        0, 1, G_M1, G_M0, 0, 0, 0);
    add("rr_m0_rsp3",     1, 1, 32'h104, 1, 32'h204, 4'h0, 1, 1, 32'h3,        0, 1, G_M0, G_M1, 0, 0, 0);
    add("rr_rsp4",        1, 0, 32'h000, 0, 32'h000, 4'h0, 1, 1, 32'h4,        0, 1, G_NO, G_M0, 0, 0, 0);
    add("lock_start",     1, 1, 32'h108, 0, 32'h000, 4'h0, 0, 0, 32'h0,        0, 1, G_M0, G_NO, 0, 0, 0);
    add("lock_hold1",     1, 1, 32'h108, 1, 32'h208, 4'h0, 0, 0, 32'h0,        0, 1, G_M0, G_NO, 0, 0, 0);
    add("lock_hold2",     1, 1, 32'h108, 1, 32'h208, 4'h0, 0, 0, 32'h0,        0, 1, G_M0, G_NO, 0, 0, 0);
    add("lock_accept",    1, 1, 32'h108, 1, 32'h208, 4'h0, 1, 0, 32'h0,        0, 1, G_M0, G_NO, 0, 0, 0);
    add("lock_m1_next",   1, 0, 32'h000, 1, 32'h208, 4'h0, 1, 0, 32'h0,        0, 1, G_M1, G_NO, 0, 0, 0);
    add("lock_rsp_m0",    1, 0, 32'h000, 0, 32'h000, 4'h0, 1, 1, 32'h11,       0, 1, G_NO, G_M0, 0, 0, 0);
    add("lock_rsp_m1",    1, 0, 32'h000, 0, 32'h000, 4'h0, 1, 1, 32'h22,       0, 1, G_NO, G_M1, 0, 0, 0);
    add("fill_1",         1, 1, 32'h10C, 0, 32'h000, 4'h0, 1, 0, 32'h0,        0, 1, G_M0, G_NO, 0, 0, 0);
    add("fill_2",         1, 0, 32'h000, 1, 32'h20C, 4'h0, 1, 0, 32'h0,        0, 1, G_M1, G_NO, 0, 0, 0);
    add("fill_3",         1, 1, 32'h110, 0, 32'h000, 4'h0, 1, 0, 32'h0,        0, 1, G_M0, G_NO, 0, 0, 0);
    add("fill_4",         1, 0, 32'h000, 1, 32'h210, 4'h0, 1, 0, 32'h0,        0, 1, G_M1, G_NO, 0, 0, 0);
    add("full_rd_held",   1, 1, 32'h114, 0, 32'h000, 4'h0, 1, 0, 32'h0,        0, 1, G_NO, G_NO, 0, 0, 0);
    add("full_wr_ok",     1, 1, 32'h114, 1, 32'h200, 4'hF, 1, 0, 32'h0,        0, 1, G_M1, G_NO, 0, 0, 0);
    add("full_rsp_free",  1, 1, 32'h114, 0, 32'h000, 4'h0, 1, 1, 32'h31,       0, 1, G_NO, G_M0, 0, 0, 0);
    add("slot_push_pop",  1, 1, 32'h114, 0, 32'h000, 4'h0, 1, 1, 32'h32,       0, 1, G_M0, G_M1, 0, 0, 0);
    add("drain_rsp3",     1, 0, 32'h000, 0, 32'h000, 4'h0, 1, 1, 32'h33,       0, 1, G_NO, G_M0, 0, 0, 0);
    add("drain_rsp4",     1, 0, 32'h000, 0, 32'h000, 4'h0, 1, 1, 32'h34,       0, 1, G_NO, G_M1, 0, 0, 0);
    add("drain_rsp5",     1, 0, 32'h000, 0, 32'h000, 4'h0, 1, 1, 32'h35,       0, 1, G_NO, G_M0, 0, 0, 0);
    add("fen_pre_m0",     1, 1, 32'h118, 0, 32'h000, 4'h0, 1, 0, 32'h0,        0, 1, G_M0, G_NO, 0, 0, 0);
    add("fen_pre_m1",     1, 0, 32'h000, 1, 32'h218, 4'h0, 1, 0, 32'h0,        0, 1, G_M1, G_NO, 0, 0, 0);
    add("fen_block",      1, 1, 32'h11C, 1, 32'h21C, 4'h0, 1, 0, 32'h0,        1, 0, G_NO, G_NO, 0, 0, 0);
    add("fen_rsp_m0",     1, 1, 32'h11C, 1, 32'h21C, 4'h0, 1, 1, 32'h41,       1, 0, G_NO, G_M0, 0, 0, 0);
    add("fen_rsp_m1",     1, 1, 32'h11C, 1, 32'h21C, 4'h0, 1, 1, 32'h42,       1, 0, G_NO, G_M1, 0, 0, 0);
    add("fen_wtb_busy",   1, 1, 32'h11C, 1, 32'h21C, 4'h0, 1, 0, 32'h0,        1, 0, G_NO, G_NO, 0, 0, 0);
    add("fen_wtb_empty",  1, 1, 32'h11C, 1, 32'h21C, 4'h0, 1, 0, 32'h0,        1, 1, G_NO, G_NO, 0, 0, 0);
    add("fen_inv",        1, 1, 32'h11C, 1, 32'h21C, 4'h0, 1, 0, 32'h0,        1, 1, G_NO, G_NO, 1, 0, 0);
    add("fen_done",       1, 1, 32'h11C, 1, 32'h21C, 4'h0, 1, 0, 32'h0,        1, 1, G_NO, G_NO, 0, 1, 0);
    add("fen_resume",     1, 1, 32'h11C, 1, 32'h21C, 4'h0, 1, 0, 32'h0,        0, 1, G_M0, G_NO, 0, 0, 0);
    add("fen_resume_rsp", 1, 0, 32'h000, 0, 32'h000, 4'h0, 1, 1, 32'h51,       0, 1, G_NO, G_M0, 0, 0, 0);
    add("cke0_comb",      0, 1, 32'h120, 0, 32'h000, 4'h0, 1, 0, 32'h0,        0, 1, G_M0, G_NO, 0, 0, 0);
    add("cke0_nopush",    1, 0, 32'h000, 0, 32'h000, 4'h0, 1, 1, 32'h61,       0, 1, G_NO, G_NO, 0, 0, 0);
    add("err_sticky",     1, 0, 32'h000, 0, 32'h000, 4'h0, 1, 0, 32'h0,        0, 1, G_NO, G_NO, 0, 0, 1);
    add("err_lock_m1",    1, 0, 32'h000, 1, 32'h230, 4'h0, 0, 0, 32'h0,        0, 1, G_M1, G_NO, 0, 0, 1);
    split = tnm.size();
    add("post_rst_rr_m1", 1, 1, 32'h124, 1, 32'h234, 4'h0, 1, 0, 32'h0,        0, 1, G_M1, G_NO, 0, 0, 0);
    add("post_rst_rsp",   1, 0, 32'h000, 0, 32'h000, 4'h0, 1, 1, 32'h77,       0, 1, G_NO, G_M1, 0, 0, 0);
    add("post_rst_orph",  1, 0, 32'h000, 0, 32'h000, 4'h0, 1, 1, 32'h78,       0, 1, G_NO, G_NO, 0, 0, 0);
    add("post_rst_err",   1, 0, 32'h000, 0, 32'h000, 4'h0, 1, 0, 32'h0,        0, 1, G_NO, G_NO, 0, 0, 1);

    // Reset state with idle inputs.
    drive('0);
    cke    = 1'b1;
    arst_n = 1'b0;
    #2;
    compare("reset_state", '0);
    @(posedge clk);
    @(posedge clk);
    #1;
    arst_n = 1'b1;

    for (int k = 0; k < split; k++) run_row(k);

    // Asynchronous reset while m1's request is locked and err_o is set:
    // state must clear without a clock edge.
    drive('0);
    cke    = 1'b1;
    wtb_empty = 1'b1;
    #1;
    arst_n = 1'b0;
    #1;
    compare("async_reset_mid_lock", '0);
    #1;
    arst_n = 1'b1;
    @(posedge clk);
    #1;

    for (int k = split; k < tnm.size(); k++) run_row(k);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
